// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state encoding and width helpers for the sequential square root
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int rad_width(input int in_w, input int frac_w);
    return in_w + 2 * frac_w;
  endfunction

  function automatic int root_width(input int in_w, input int frac_w);
    return rad_width(in_w, frac_w) / 2;
  endfunction

  function automatic int rem_width(input int in_w, input int frac_w);
    return root_width(in_w, frac_w) + 1;
  endfunction

  // A one-bit root still needs a one-bit counter.
  function automatic int count_width(input int in_w, input int frac_w);
    int c;
    c = clog2(root_width(in_w, frac_w));
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring digit step: shift in a radicand pair, trial-subtract, emit one root bit
module sqrt_step #(
  parameter int OUT_W = 12
) (
  input  logic [OUT_W-1:0] rem_in,
  input  logic [OUT_W-1:0] root_in,
  input  logic [1:0]       pair,
  output logic [OUT_W:0]   rem_out,
  output logic [OUT_W-1:0] root_out
);

  logic [OUT_W+1:0] rem_sh;
  logic [OUT_W+1:0] trial;
  logic [OUT_W:0]   diff;
  logic             fits;

  // The surviving remainder never exceeds 2*root, so the low OUT_W+1 bits of the difference suffice.
  always_comb begin
    rem_sh  = {rem_in, pair};
    trial   = {root_in, 2'b01};
    fits    = (rem_sh >= trial);
    diff    = rem_sh[OUT_W:0] - trial[OUT_W:0];
    rem_out = fits ? diff : rem_sh[OUT_W:0];
  end

  if (OUT_W > 1) begin : g_wide
    assign root_out = {root_in[OUT_W-2:0], fits};
  end else begin : g_one
    assign root_out = fits;
  end

endmodule

// File: rtl/seq_square_root.sv
// rtl/seq_square_root.sv - iterative fixed-point square root, one root bit per clock with valid/ready handshake
module seq_square_root
  import sqrt_pkg::*;
#(
  parameter  int IN_W   = 8,
  parameter  int FRAC_W = 8,
  localparam int RAD_W  = rad_width(IN_W, FRAC_W),
  localparam int OUT_W  = root_width(IN_W, FRAC_W),
  localparam int REM_W  = rem_width(IN_W, FRAC_W),
  localparam int CNT_W  = count_width(IN_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_root,
  output logic [REM_W-1:0] out_rem,
  output logic             out_exact,
  output logic             busy
);

  state_t           state, state_next;
  logic [RAD_W-1:0] rad_q;
  logic [OUT_W-1:0] rem_q;
  logic [OUT_W-1:0] root_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REM_W-1:0] step_rem;
  logic [OUT_W-1:0] step_root;
  logic             accept;
  logic             last_step;

  sqrt_step #(.OUT_W(OUT_W)) u_step (
    .rem_in   (rem_q),
    .root_in  (root_q),
    .pair     (rad_q[RAD_W-1 -: 2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

  assign in_ready  = (state == IDLE) && !clear;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state == CALC) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)    state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Result registers update only on an uncleared final step so an abort leaves the last result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      out_root  <= '0;
      out_rem   <= '0;
      out_exact <= 1'b0;
    end else if (!clear) begin
      if (accept) begin
        rad_q  <= RAD_W'(in_data) << (2 * FRAC_W);
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= CNT_W'(OUT_W - 1);
      end else if (state == CALC) begin
        rad_q  <= rad_q << 2;
        rem_q  <= step_rem[OUT_W-1:0];
        root_q <= step_root;
        cnt_q  <= cnt_q - 1'b1;
        if (last_step) begin
          out_root  <= step_root;
          out_rem   <= step_rem;
          out_exact <= (step_rem == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_square_root.sv
// tb/tb_seq_square_root.sv - directed self-checking bench for seq_square_root (default and 16.0 configurations)
module tb_seq_square_root;

  logic        clk;
  logic        rst_n;
  logic        clear;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_exact, a_busy;
  logic [7:0]  a_in_data;
  logic [11:0] a_out_root;
  logic [12:0] a_out_rem;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_exact, b_busy;
  logic [15:0] b_in_data;
  logic [7:0]  b_out_root;
  logic [8:0]  b_out_rem;

  int checks = 0;
  int errors = 0;

  seq_square_root u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_root(a_out_root), .out_rem(a_out_rem), .out_exact(a_out_exact), .busy(a_busy)
  );

  seq_square_root #(.IN_W(16), .FRAC_W(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_root(b_out_root), .out_rem(b_out_rem), .out_exact(b_out_exact), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Full transaction on the default instance, with optional consumer stall in DONE.
  task automatic op_a(input logic [7:0] d, input logic [11:0] er, input logic [12:0] erem,
                      input logic ex, input int stall);
    int cyc;
    logic hold_ok;
    cyc = 0;
    while (!a_in_ready && cyc < 50) begin tick(); cyc++; end
    a_in_valid = 1'b1;
    a_in_data  = d;
    tick();
    a_in_valid = 1'b0;
    a_in_data  = 8'hA5;
    cyc = 0;
    hold_ok = 1'b1;
    while (!a_out_valid && cyc < 40) begin
      if (a_in_ready !== 1'b0 || a_busy !== 1'b1) hold_ok = 1'b0;
      tick();
      cyc++;
    end
    check("latency", cyc, 12);
    check("root", a_out_root, er);
    check("rem", a_out_rem, erem);
    check("exact", a_out_exact, ex);
    for (int i = 0; i < stall; i++) begin
      if (a_out_valid !== 1'b1 || a_out_root !== er || a_out_rem !== erem) hold_ok = 1'b0;
      tick();
    end
    if (a_in_ready !== 1'b0) hold_ok = 1'b0;
    check("busy_phase_hold", hold_ok, 1'b1);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("valid_drop", a_out_valid, 1'b0);
    check("ready_back", a_in_ready, 1'b1);
    check("root_kept", a_out_root, er);
  endtask

  task automatic op_b(input int d);
    int cyc;
    int er;
    er = isqrt(d);
    cyc = 0;
    while (!b_in_ready && cyc < 50) begin tick(); cyc++; end
    b_in_valid = 1'b1;
    b_in_data  = 16'(d);
    tick();
    b_in_valid = 1'b0;
    cyc = 0;
    while (!b_out_valid && cyc < 40) begin tick(); cyc++; end
    check("b_latency", cyc, 8);
    check("b_root", b_out_root, er);
    check("b_rem", b_out_rem, d - er * er);
    check("b_exact", b_out_exact, (d == er * er));
    tick();
  endtask

  initial begin
    int cyc;
    logic quiet;
    rst_n = 1'b0; clear = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_root", a_out_root, 0);
    check("rst_rem", a_out_rem, 0);
    check("rst_exact", a_out_exact, 1'b0);
    rst_n = 1'b1;
    tick();

    op_a(8'd4,   12'h200, 13'd0,    1'b1, 0);
    op_a(8'd2,   12'd362, 13'd28,   1'b0, 0);
    op_a(8'd255, 12'd4087, 13'd8111, 1'b0, 5);
    op_a(8'd0,   12'd0,   13'd0,    1'b1, 0);
    op_a(8'd1,   12'd256, 13'd0,    1'b1, 1);

    // Abort in the middle of CALC, then try to sneak an operand in while clear is held.
    a_in_valid = 1'b1; a_in_data = 8'd200;
    tick();
    a_in_valid = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    check("clr_busy", a_busy, 1'b0);
    check("clr_valid", a_out_valid, 1'b0);
    a_in_valid = 1'b1; a_in_data = 8'd7;
    check("clr_in_ready", a_in_ready, 1'b0);
    tick();
    check("clr_no_accept", a_busy, 1'b0);
    clear = 1'b0; a_in_valid = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (a_out_valid !== 1'b0 || a_busy !== 1'b0) quiet = 1'b0;
      tick();
    end
    check("clr_quiet", quiet, 1'b1);
    check("clr_root_kept", a_out_root, 12'd256);
    op_a(8'd9, 12'd768, 13'd0, 1'b1, 0);

    // Asynchronous reset between clock edges, mid-CALC.
    a_in_valid = 1'b1; a_in_data = 8'd81;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", a_busy, 1'b0);
    check("arst_valid", a_out_valid, 1'b0);
    check("arst_root", a_out_root, 0);
    check("arst_in_ready", a_in_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    cyc = 0;
    while (cyc < 20) begin
      if (a_out_valid !== 1'b0) break;
      tick();
      cyc++;
    end
    check("arst_no_partial", cyc, 20);
    op_a(8'd81, 12'd2304, 13'd0, 1'b1, 0);

    // 16.0 configuration: edge values plus a strided sweep against the floor-sqrt model.
    op_b(0); op_b(1); op_b(2); op_b(3); op_b(255); op_b(256);
    op_b(65024); op_b(65025); op_b(65535);
    for (int v = 7; v < 65536; v += 241) op_b(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
